// File: rtl/seg7_pkg.sv
// Shared definitions for seven-segment stream blocks: segment patterns,
// compact character codes, decoder FSM states and the expected message frame.
package seg7_pkg;

  // Segment patterns as seen on the pins, {dp,a,b,c,d,e,f,g}
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_DP    = 8'h80;
  localparam logic [7:0] SEG_S     = 8'h5B;
  localparam logic [7:0] SEG_E     = 8'h4F;
  localparam logic [7:0] SEG_N     = 8'h15;
  localparam logic [7:0] SEG_O     = 8'h7E;
  localparam logic [7:0] SEG_L     = 8'h0E;
  localparam logic [7:0] SEG_G     = 8'h5F;
  localparam logic [7:0] SEG_U     = 8'h3E;

  // Compact character codes
  localparam logic [3:0] CHAR_BLANK = 4'h0;
  localparam logic [3:0] CHAR_DP    = 4'h1;
  localparam logic [3:0] CHAR_S     = 4'h2;
  localparam logic [3:0] CHAR_E     = 4'h3;
  localparam logic [3:0] CHAR_N     = 4'h4;
  localparam logic [3:0] CHAR_O     = 4'h5;
  localparam logic [3:0] CHAR_L     = 4'h6;
  localparam logic [3:0] CHAR_G     = 4'h7;
  localparam logic [3:0] CHAR_U     = 4'h8;
  localparam logic [3:0] CHAR_UNK   = 4'hF;

  typedef enum logic {HUNT, TRACK} state_e;

  localparam int unsigned MSG_LEN  = 14;
  localparam logic [3:0]  POS_LAST = 4'(MSG_LEN - 1);

  // Expected character at each frame position: "dp S E n O L G U L G O n U L"
  function automatic logic [3:0] exp_char(input logic [3:0] pos);
    logic [3:0] c;
    case (pos)
      4'd0:    c = CHAR_DP;
      4'd1:    c = CHAR_S;
      4'd2:    c = CHAR_E;
      4'd3:    c = CHAR_N;
      4'd4:    c = CHAR_O;
      4'd5:    c = CHAR_L;
      4'd6:    c = CHAR_G;
      4'd7:    c = CHAR_U;
      4'd8:    c = CHAR_L;
      4'd9:    c = CHAR_G;
      4'd10:   c = CHAR_O;
      4'd11:   c = CHAR_N;
      4'd12:   c = CHAR_U;
      4'd13:   c = CHAR_L;
      default: c = CHAR_UNK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/seg7_char_lut.sv
// Combinational segment-pattern to character-code lookup. Exact match only;
// anything unrecognised maps to CHAR_UNK.
module seg7_char_lut
  import seg7_pkg::*;
(
  input  logic [7:0] seg,
  output logic [3:0] code
);

  // Pattern decode
  always_comb begin
    code = CHAR_UNK;
    case (seg)
      SEG_BLANK: code = CHAR_BLANK;
      SEG_DP:    code = CHAR_DP;
      SEG_S:     code = CHAR_S;
      SEG_E:     code = CHAR_E;
      SEG_N:     code = CHAR_N;
      SEG_O:     code = CHAR_O;
      SEG_L:     code = CHAR_L;
      SEG_G:     code = CHAR_G;
      SEG_U:     code = CHAR_U;
      default:   code = CHAR_UNK;
    endcase
  end

endmodule

// File: rtl/seg7_stream_decoder.sv
// Seven-segment stream decoder: decodes sampled segment patterns, tracks the
// 14-symbol message frame, reports lock, frame completion and error count.
// Optional SEG_SYNC_EN: 2-flop input synchronizer (adds 2 cycles of latency).
module seg7_stream_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned ERR_W       = 8,
  parameter int unsigned LOCK_FRAMES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       seg_in,
  input  logic             seg_valid,
  output logic [3:0]       char_out,
  output logic             char_valid,
  output logic             locked,
  output logic             frame_done,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [1:0] LockTgt = 2'(LOCK_FRAMES);

  logic [7:0] smp_seg;
  logic       smp_valid;

`ifdef SEG_SYNC_EN
  logic [7:0] seg_s1_q, seg_s2_q;
  logic       valid_s1_q, valid_s2_q;

  // Two-flop synchronizer on pattern and strobe together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q   <= '0;
      seg_s2_q   <= '0;
      valid_s1_q <= 1'b0;
      valid_s2_q <= 1'b0;
    end else begin
      seg_s1_q   <= seg_in;
      seg_s2_q   <= seg_s1_q;
      valid_s1_q <= seg_valid;
      valid_s2_q <= valid_s1_q;
    end
  end

  assign smp_seg   = seg_s2_q;
  assign smp_valid = valid_s2_q;
`else
  assign smp_seg   = seg_in;
  assign smp_valid = seg_valid;
`endif

  logic [3:0] code;

  seg7_char_lut u_lut (
    .seg  (smp_seg),
    .code (code)
  );

  state_e           state_q, state_d;
  logic [3:0]       pos_q, pos_d;
  logic [1:0]       frames_q, frames_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [3:0]       char_q, char_d;
  logic             char_valid_q, char_valid_d;
  logic             locked_q, locked_d;
  logic             frame_done_q, frame_done_d;
  logic [1:0]       frames_inc;

  // Frame counter saturates at the lock threshold
  assign frames_inc = (frames_q >= LockTgt) ? LockTgt : frames_q + 2'd1;

  // Next-state: decode result drives the frame tracker
  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    frames_d     = frames_q;
    err_d        = err_q;
    char_d       = char_q;
    locked_d     = locked_q;
    char_valid_d = 1'b0;
    frame_done_d = 1'b0;
    if (smp_valid) begin
      char_d       = code;
      char_valid_d = 1'b1;
      case (state_q)
        HUNT: begin
          if (code == CHAR_DP) begin
            state_d = TRACK;
            pos_d   = 4'd1;
          end else if (code == CHAR_UNK && err_q != '1) begin
            err_d = err_q + ERR_W'(1);
          end
        end
        TRACK: begin
          if (code == exp_char(pos_q)) begin
            if (pos_q == POS_LAST) begin
              frame_done_d = 1'b1;
              pos_d        = 4'd0;
              frames_d     = frames_inc;
              if (frames_inc >= LockTgt) locked_d = 1'b1;
            end else begin
              pos_d = pos_q + 4'd1;
            end
          end else begin
            if (err_q != '1) err_d = err_q + ERR_W'(1);
            locked_d = 1'b0;
            frames_d = 2'd0;
            // A stray dp is treated as the start of a new frame
            if (code == CHAR_DP) begin
              pos_d = 4'd1;
            end else begin
              state_d = HUNT;
              pos_d   = 4'd0;
            end
          end
        end
        default: begin
          state_d = HUNT;
          pos_d   = 4'd0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      pos_q        <= 4'd0;
      frames_q     <= 2'd0;
      err_q        <= '0;
      char_q       <= 4'd0;
      char_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      frames_q     <= frames_d;
      err_q        <= err_d;
      char_q       <= char_d;
      char_valid_q <= char_valid_d;
      locked_q     <= locked_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign char_out   = char_q;
  assign char_valid = char_valid_q;
  assign locked     = locked_q;
  assign frame_done = frame_done_q;
  assign err_cnt    = err_q;

endmodule

// File: tb/tb_seg7_stream_decoder.sv
// Scoreboard bench for seg7_stream_decoder: each driven sample pushes its
// expected outputs and arrival cycle; the monitor pops on char_valid.
`timescale 1ns/1ps
module tb_seg7_stream_decoder;

  localparam int ERR_W       = 8;
  localparam int LOCK_FRAMES = 1;
  localparam int ERR_MAX     = (1 << ERR_W) - 1;
`ifdef SEG_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [7:0]       seg_in = 8'h00;
  logic             seg_valid = 1'b0;
  logic [3:0]       char_out;
  logic             char_valid;
  logic             locked;
  logic             frame_done;
  logic [ERR_W-1:0] err_cnt;

  seg7_stream_decoder #(
    .ERR_W       (ERR_W),
    .LOCK_FRAMES (LOCK_FRAMES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_in     (seg_in),
    .seg_valid  (seg_valid),
    .char_out   (char_out),
    .char_valid (char_valid),
    .locked     (locked),
    .frame_done (frame_done),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int ch;
    int fd;
    int lk;
    int err;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [7:0] msg [14] = '{8'h80, 8'h5B, 8'h4F, 8'h15, 8'h7E, 8'h0E, 8'h5F,
                           8'h3E, 8'h0E, 8'h5F, 8'h7E, 8'h15, 8'h3E, 8'h0E};
  int rom [14] = '{1, 2, 3, 4, 5, 6, 7, 8, 6, 7, 5, 4, 8, 6};

  // Reference model state
  int m_track = 0, m_pos = 0, m_frames = 0, m_locked = 0, m_err = 0;

  task automatic check_eq(input string tag, input int obs, input int want);
    n_checks++;
    if (obs != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, want, $time);
    end
  endtask

  function automatic int ref_decode(input logic [7:0] s);
    case (s)
      8'h00: return 0;
      8'h80: return 1;
      8'h5B: return 2;
      8'h4F: return 3;
      8'h15: return 4;
      8'h7E: return 5;
      8'h0E: return 6;
      8'h5F: return 7;
      8'h3E: return 8;
      default: return 15;
    endcase
  endfunction

  task automatic model_reset();
    m_track = 0; m_pos = 0; m_frames = 0; m_locked = 0; m_err = 0;
  endtask

  task automatic bump_err();
    if (m_err < ERR_MAX) m_err++;
  endtask

  task automatic send(input logic [7:0] s);
    exp_t e;
    int   c;
    @(negedge clk);
    seg_in    = s;
    seg_valid = 1'b1;
    c    = ref_decode(s);
    e.fd = 0;
    if (m_track == 0) begin
      if (c == 1) begin
        m_track = 1;
        m_pos   = 1;
      end else if (c == 15) begin
        bump_err();
      end
    end else if (c == rom[m_pos]) begin
      if (m_pos == 13) begin
        e.fd  = 1;
        m_pos = 0;
        if (m_frames < LOCK_FRAMES) m_frames++;
        if (m_frames >= LOCK_FRAMES) m_locked = 1;
      end else begin
        m_pos++;
      end
    end else begin
      bump_err();
      m_locked = 0;
      m_frames = 0;
      if (c == 1) m_pos = 1;
      else begin
        m_track = 0;
        m_pos   = 0;
      end
    end
    e.ch  = c;
    e.lk  = m_locked;
    e.err = m_err;
    e.cyc = cyc + LAT;
    sb.push_back(e);
  endtask

  task automatic gap(input logic [7:0] s);
    @(negedge clk);
    seg_in    = s;
    seg_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) gap(8'h00);
  endtask

  task automatic send_frame();
    for (int i = 0; i < 14; i++) send(msg[i]);
  endtask

  // Drain the pipeline and confirm every expectation was consumed
  task automatic drain(input string tag);
    idle(LAT + 2);
    check_eq(tag, sb.size(), 0);
  endtask

  task automatic do_reset();
    seg_valid = 1'b0;
    rst_n     = 1'b0;
    sb.delete();
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_char_out"}, int'(char_out), 0);
    check_eq({tag, "_char_valid"}, int'(char_valid), 0);
    check_eq({tag, "_locked"}, int'(locked), 0);
    check_eq({tag, "_frame_done"}, int'(frame_done), 0);
    check_eq({tag, "_err_cnt"}, int'(err_cnt), 0);
  endtask

  // Output monitor, sampled 1ns after the active edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n) begin
      if (char_valid) begin
        check_eq("pending_exp", (sb.size() > 0) ? 1 : 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check_eq("latency", cyc, e.cyc);
          check_eq("char_out", int'(char_out), e.ch);
          check_eq("frame_done", int'(frame_done), e.fd);
          check_eq("locked", int'(locked), e.lk);
          check_eq("err_cnt", int'(err_cnt), e.err);
        end
      end else begin
        check_eq("frame_done_idle", int'(frame_done), 0);
      end
    end
  end

  initial begin
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("reset");
    do_reset();

    // Three back-to-back frames from the first cycle after reset
    for (int f = 0; f < 3; f++) send_frame();
    drain("t1_drain");
    check_eq("t1_locked", int'(locked), 1);
    check_eq("t1_err", int'(err_cnt), 0);

    // Start mid-frame at O: no errors while hunting, lock on next full frame
    do_reset();
    for (int i = 4; i < 14; i++) send(msg[i]);
    check_eq("t2_hunt_err", m_err, 0);
    send_frame();
    drain("t2_drain");
    check_eq("t2_locked", int'(locked), 1);
    check_eq("t2_err", int'(err_cnt), 0);

    // Corrupt the 6th symbol: error, unlock, hunt, then relock
    for (int i = 0; i < 14; i++) send((i == 5) ? 8'h01 : msg[i]);
    drain("t3a_drain");
    check_eq("t3_unlocked", int'(locked), 0);
    check_eq("t3_err", int'(err_cnt), 1);
    send_frame();
    drain("t3b_drain");
    check_eq("t3_relocked", int'(locked), 1);

    // Stray dp at pos 5: immediate resync, 13 more symbols finish the frame
    for (int i = 0; i < 5; i++) send(msg[i]);
    send(8'h80);
    for (int i = 1; i < 14; i++) send(msg[i]);
    drain("t4_drain");
    check_eq("t4_err", int'(err_cnt), 2);
    check_eq("t4_locked", int'(locked), 1);

    // Error counter saturation
    for (int i = 0; i < 300; i++) send(8'h01);
    drain("t5_drain");
    check_eq("t5_err_sat", int'(err_cnt), ERR_MAX);

    // Frame with gaps; junk on seg_in while seg_valid is low must be ignored
    for (int i = 0; i < 14; i++) begin
      send(msg[i]);
      gap(8'h01);
    end
    drain("t6_drain");
    check_eq("t6_locked", int'(locked), 1);
    check_eq("t6_err", int'(err_cnt), ERR_MAX);

    // Asynchronous reset mid-frame
    for (int i = 0; i < 7; i++) send(msg[i]);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    model_reset();
    #1 check_zero_outputs("midrst");
    seg_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_frame();
    drain("t7_drain");
    check_eq("t7_locked", int'(locked), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seg7_stream_decoder.md
Name: seg7_stream_decoder

Overview:
Receive-side counterpart of the scrolling seven-segment message writer. Samples 8-bit segment patterns ({dp,a,b,c,d,e,f,g}) from the pins. Decodes each pattern to a compact character code and tracks the 14-symbol message frame "dp S E n O L G U L G O n U L". Reports lock, per-frame completion and an error count. Placed inside the tile top to loop back or monitor the segment bus of a second device.

Parameters:
ERR_W, 8, width of the saturating error counter
LOCK_FRAMES, 1, number of consecutive error-free frames required before locked asserts (1..3)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
seg_in  in  8  segment pattern, bit7=dp, bits6:0=a..g
seg_valid  in  1  sample strobe; seg_in is sampled on a rising clk edge while high
char_out  out  4  decoded character code
char_valid  out  1  one-cycle pulse, char_out updated
locked  out  1  frame alignment established
frame_done  out  1  one-cycle pulse on the last symbol (L) of a correct frame
err_cnt  out  ERR_W  saturating count of decode or sequence errors

Behaviour:
- Reset: an asynchronous low on rst_n clears all outputs to 0. The FSM goes to HUNT, pos goes to 0, and the frame counter goes to 0.
- Decode table (exact match, otherwise code 0xF = UNK):
  - 0x00→0 blank
  - 0x80→1 dp
  - 0x5B→2 S
  - 0x4F→3 E
  - 0x15→4 n
  - 0x7E→5 O
  - 0x0E→6 L
  - 0x5F→7 G
  - 0x3E→8 U
- Latency: char_out/char_valid are registered and appear 1 cycle after the sampling edge.
- Expected-symbol ROM, pos 0..13: 1,2,3,4,5,6,7,8,6,7,5,4,8,6.
- FSM HUNT:
  - A valid sample decoding to dp moves to TRACK with pos=1.
  - Any other code stays in HUNT. UNK increments err_cnt; blank does not.
- FSM TRACK, on each valid sample, compare the code with ROM[pos]:
  - Match and pos<13: pos+1.
  - Match and pos==13: frame_done pulses, pos=0 (dp expected next), frame counter increments (saturates at LOCK_FRAMES). Locked asserts in the same cycle as frame_done once the counter reaches LOCK_FRAMES.
  - Mismatch: err_cnt+1, locked=0, frame counter=0.
    - If the mismatching code is dp, resynchronise directly to pos=1 and stay in TRACK.
    - Otherwise go to HUNT.
- err_cnt saturates at all-ones and never wraps.
- seg_valid low: no state change, char_valid=0, frame_done=0.
- Back-to-back samples every cycle are supported (writer rate = 1 symbol/clk).
- Reset asserted mid-frame aborts immediately. There is no partial-frame memory.

Optional Feature:
SEG_SYNC_EN:
- Defined: seg_in and seg_valid pass through a 2-flop synchronizer before decode. Total latency from pin to char_valid is 3 cycles, and every downstream timing shifts by 2 cycles.
- Undefined: inputs are sampled directly, with 1-cycle latency as above.

Decomposition:
Shared package seg7_pkg, containing:
- segment pattern constants (SEG_BLANK, SEG_DP, SEG_S … SEG_U)
- 4-bit character code constants and CHAR_UNK=0xF
- FSM state typedef {HUNT, TRACK}
- message length constant MSG_LEN=14

One sub-module: seg7_char_lut, a pure combinational pattern→code lookup that is reusable by other display blocks. The FSM, ROM, counters and synchronizer stay in seg7_stream_decoder.

Test Plan:
- Reset, then drive 3 full frames back-to-back from cycle 0 starting with 0x80 → first frame_done on the 14th sample; locked=1 from that cycle (LOCK_FRAMES=1); err_cnt=0; char_out sequence 1,2,3,4,5,6,7,8,6,7,5,4,8,6.
- Start stream mid-frame at symbol O (0x7E) → stays HUNT with err_cnt=0 until dp; lock on the first complete frame thereafter.
- Locked, then replace 6th symbol L with 0x01 → char_out=0xF, err_cnt=1, locked=0, back to HUNT; relock after the next full frame.
- Locked, then inject 0x80 at pos 5 → err_cnt+1 and immediate resync (pos=1); the next 13 correct symbols produce frame_done.
- Force 300 UNK samples with ERR_W=8 → err_cnt holds at 255.
- Toggle seg_valid low every other cycle during a frame → identical char_out sequence with gaps; assert rst_n low mid-frame → all outputs 0 asynchronously; rebuild SEG_SYNC_EN and confirm the 3-cycle latency.
